sipo_collector: RTL and testbench
=================================

SIPO_COLLECTOR -- requirements
Module: sipo_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits (legal range 2..32).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning that the first received bit lands in dout[WIDTH-1] (0 means it lands in dout[0]).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port clrn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port din, input, 1 bit: serial data bit, typically driven by an upstream flip-flop stage.
REQ-006 SHALL have port din_en, input, 1 bit: din is sampled on this cycle's edge when high.
REQ-007 SHALL have port flush, input, 1 bit: synchronous abort of the partial word and the output buffer.
REQ-008 SHALL have port dout, output, WIDTH bits: assembled parallel word.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-010 SHALL have port dout_ready, input, 1 bit: consumer accepts dout when high together with dout_valid.
REQ-011 SHALL have port busy, output, 1 bit: a partial word is being collected.
REQ-012 SHALL have port overrun, output, 1 bit: sticky flag, set when a completed word is dropped.
REQ-013 SHALL have port ovr_clr, input, 1 bit: synchronous clear of overrun.

Function
REQ-014 Collector FSM SHALL have exactly two states, IDLE (bit count 0) and SHIFT (bit count 1..WIDTH-1); busy SHALL be 1 exactly in SHIFT.
REQ-015 In IDLE, din_en=1 SHALL capture din as bit 1, set count=1 and enter SHIFT; din_en=0 SHALL leave state unchanged.
REQ-016 In SHIFT, din_en=1 SHALL shift din in and increment count; din_en=0 SHALL hold the shift register and count (gaps allowed, no timeout).
REQ-017 The cycle in which the WIDTH-th bit is sampled SHALL complete the word, reset count to 0 and return to IDLE.
REQ-018 On completion with the output buffer empty, or with dout_valid&dout_ready in the same cycle, dout SHALL load the word and dout_valid SHALL be 1 on the following cycle (latency 1 clock after the last bit edge).
REQ-019 On completion with dout_valid=1 and dout_ready=0, the new word SHALL be dropped, dout SHALL remain unchanged, and overrun SHALL be set to 1.
REQ-020 Handshake: dout_valid=1 and dout_ready=1 with no simultaneous completion SHALL clear dout_valid next cycle; dout SHALL retain its last value.
REQ-021 dout and dout_valid SHALL NOT change while dout_valid=1 and dout_ready=0, except by flush or reset.
REQ-022 flush=1 SHALL force IDLE, count 0 and dout_valid 0, leave overrun unchanged, and take priority over din_en and completion in the same cycle.
REQ-023 overrun SHALL stay 1 until ovr_clr=1 or reset; a set condition and ovr_clr=1 in the same cycle SHALL leave overrun at 1 (set wins).
REQ-024 MSB_FIRST=1 SHALL shift toward the MSB (new bit into bit 0); MSB_FIRST=0 SHALL shift toward the LSB (new bit into bit WIDTH-1).

Reset
REQ-025 clrn=0 SHALL immediately, without a clock, force IDLE, count=0, shift register=0, dout=0, dout_valid=0, busy=0 and overrun=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word, and the first din_en bit after release SHALL be bit 1 of a new word.

Structure
REQ-027 Shared package sipo_pkg SHALL hold the FSM state encoding (IDLE, SHIFT) and the WIDTH default constant.
REQ-028 The shift register, bit counter and FSM SHALL live in the sub-module sipo_shift_core; the top SHALL own the output buffer, the handshake and the overrun flag.

Verification
REQ-029 Reset, then 8 consecutive din_en bits 1,0,1,0,0,1,0,1 with MSB_FIRST=1 -> dout=8'hA5, with dout_valid=1 on the cycle after the 8th edge and busy=0 at that point.
REQ-030 8'hA5 held with dout_ready=0, then 8'h3C fully shifted in -> overrun=1, dout stays 8'hA5; ovr_clr pulse -> overrun=0.
REQ-031 8'hA5 held; the 8th bit of 8'h3C arrives in the same cycle as dout_ready=1 -> no overrun, next cycle dout=8'h3C and dout_valid=1.
REQ-032 8'hA5 sent with 3-cycle din_en gaps between bits -> dout=8'hA5, and busy=1 throughout the gaps.
REQ-033 clrn pulsed low after 5 bits, then 8 bits of 8'hFF -> dout=8'hFF and no residue from the earlier bits; flush after 4 bits behaves the same.
REQ-034 With MSB_FIRST=0, bit sequence 1,0,0,0,0,0,0,0 -> dout=8'h01.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out collector:
// collector FSM encoding and the default word length.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_e;

  localparam int SIPO_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sipo_collector_if.sv
// Serial input, output-buffer handshake and overrun signals of the collector.
// The master side drives serial data and consumes words; the slave side is the collector.
interface sipo_collector_if
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEFAULT
);

  logic             din;
  logic             din_en;
  logic             flush;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             busy;
  logic             overrun;
  logic             ovr_clr;

  modport master (
    output din, din_en, flush, dout_ready, ovr_clr,
    input  dout, dout_valid, busy, overrun
  );

  modport slave (
    input  din, din_en, flush, dout_ready, ovr_clr,
    output dout, dout_valid, busy, overrun
  );

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register, bit counter and IDLE/SHIFT FSM of the collector.
// o_done pulses combinationally in the cycle the last bit is sampled; o_word is the finished word.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             i_din,
  input  logic             i_din_en,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_word
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sipo_state_e      r_state,  w_state_nxt;
  logic [CW-1:0]    r_count,  w_count_nxt;
  logic [WIDTH-1:0] r_shreg,  w_shreg_nxt;
  logic [WIDTH-1:0] w_base,   w_shifted;

  // A new word always starts from zero so no bits of the previous word leak in.
  assign w_base = (r_state == SHIFT) ? r_shreg : '0;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shifted = {w_base[WIDTH-2:0], i_din};
    end else begin : g_lsb_first
      assign w_shifted = {i_din, w_base[WIDTH-1:1]};
    end
  endgenerate

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_shreg_nxt = r_shreg;
    o_done      = 1'b0;
    if (i_flush) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
      w_shreg_nxt = '0;
    end else if (i_din_en) begin
      w_shreg_nxt = w_shifted;
      unique case (r_state)
        IDLE: begin
          w_state_nxt = SHIFT;
          w_count_nxt = CW'(1);
        end
        SHIFT: begin
          if (r_count == LAST) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
            o_done      = 1'b1;
          end else begin
            w_count_nxt = r_count + CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_count <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  assign o_busy = (r_state == SHIFT);
  assign o_word = w_shifted;

endmodule

// File: rtl/sipo_collector.sv
// Serial-to-parallel collector: assembles WIDTH-bit words from a gated bit stream and
// presents them through a one-entry valid/ready output buffer with a sticky overrun flag.
module sipo_collector
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH_DEFAULT,
  parameter int MSB_FIRST = 1
) (
  input  logic           clk,
  input  logic           clrn,
  sipo_collector_if.slave bus
);

  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic             w_load;
  logic             w_drop;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk      (clk),
    .clrn     (clrn),
    .i_din    (bus.din),
    .i_din_en (bus.din_en),
    .i_flush  (bus.flush),
    .o_busy   (bus.busy),
    .o_done   (w_done),
    .o_word   (w_word)
  );

  // The core already suppresses completion during flush.
  assign w_load = w_done && (!r_dout_valid || bus.dout_ready);
  assign w_drop = w_done && r_dout_valid && !bus.dout_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (bus.flush) begin
      r_dout_valid <= 1'b0;
    end else if (w_load) begin
      r_dout       <= w_word;
      r_dout_valid <= 1'b1;
    end else if (r_dout_valid && bus.dout_ready) begin
      r_dout_valid <= 1'b0;
    end
  end

  // Setting has priority over clearing so a drop in the clear cycle is never lost.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (bus.ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_collector.sv
// Directed bench for sipo_collector: one MSB-first and one LSB-first instance,
// hand-computed expected words, handshake, overrun, gap, reset and flush cases.
module tb_sipo_collector;
  import sipo_pkg::*;

  logic clk;
  logic clrn;
  int   n_checks;
  int   n_errors;

  sipo_collector_if #(.WIDTH(8)) if_m ();
  sipo_collector_if #(.WIDTH(8)) if_l ();

  sipo_collector #(.WIDTH(8), .MSB_FIRST(1)) u_dut_msb (
    .clk  (clk),
    .clrn (clrn),
    .bus  (if_m)
  );

  sipo_collector #(.WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (
    .clk  (clk),
    .clrn (clrn),
    .bus  (if_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if_m.din    = b;
    if_m.din_en = 1'b1;
    tick();
    if_m.din_en = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic consume();
    if_m.dout_ready = 1'b1;
    tick();
    if_m.dout_ready = 1'b0;
  endtask

  task automatic send_bit_l(input logic b);
    if_l.din    = b;
    if_l.din_en = 1'b1;
    tick();
    if_l.din_en = 1'b0;
  endtask

  initial begin
    logic [7:0] w_seq;
    n_checks = 0;
    n_errors = 0;
    clrn = 1'b0;
    {if_m.din, if_m.din_en, if_m.flush, if_m.dout_ready, if_m.ovr_clr} = '0;
    {if_l.din, if_l.din_en, if_l.flush, if_l.ovr_clr} = '0;
    if_l.dout_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy",    32'(if_m.busy),       32'd0);
    check("rst_valid",   32'(if_m.dout_valid), 32'd0);
    check("rst_dout",    32'(if_m.dout),       32'd0);
    check("rst_overrun", 32'(if_m.overrun),    32'd0);
    clrn = 1'b1;
    tick();

    // First word A5, consecutive bits, consumer not ready
    w_seq = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(w_seq[i]);
    check("a5_busy_mid",  32'(if_m.busy),       32'd1);
    check("a5_valid_mid", 32'(if_m.dout_valid), 32'd0);
    send_bit(w_seq[0]);
    check("a5_dout",  32'(if_m.dout),       32'hA5);
    check("a5_valid", 32'(if_m.dout_valid), 32'd1);
    check("a5_busy",  32'(if_m.busy),       32'd0);

    // Dropped word while A5 is held
    send_word(8'h3C);
    check("ovr_set",   32'(if_m.overrun),    32'd1);
    check("ovr_dout",  32'(if_m.dout),       32'hA5);
    check("ovr_valid", 32'(if_m.dout_valid), 32'd1);
    if_m.ovr_clr = 1'b1;
    tick();
    if_m.ovr_clr = 1'b0;
    check("ovr_clr", 32'(if_m.overrun), 32'd0);

    // Completion coincides with consumption
    w_seq = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(w_seq[i]);
    if_m.dout_ready = 1'b1;
    send_bit(w_seq[0]);
    if_m.dout_ready = 1'b0;
    check("same_cyc_dout",    32'(if_m.dout),       32'h3C);
    check("same_cyc_valid",   32'(if_m.dout_valid), 32'd1);
    check("same_cyc_overrun", 32'(if_m.overrun),    32'd0);
    consume();
    check("hs_valid", 32'(if_m.dout_valid), 32'd0);
    check("hs_dout",  32'(if_m.dout),       32'h3C);

    // Overrun set and ovr_clr in the same cycle; flush keeps overrun
    send_word(8'hA5);
    w_seq = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(w_seq[i]);
    if_m.ovr_clr = 1'b1;
    send_bit(w_seq[0]);
    if_m.ovr_clr = 1'b0;
    check("set_wins", 32'(if_m.overrun), 32'd1);
    if_m.flush = 1'b1;
    tick();
    if_m.flush = 1'b0;
    check("flush_valid",   32'(if_m.dout_valid), 32'd0);
    check("flush_overrun", 32'(if_m.overrun),    32'd1);
    if_m.ovr_clr = 1'b1;
    tick();
    if_m.ovr_clr = 1'b0;

    // Gaps of three idle cycles between bits
    w_seq = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w_seq[i]);
      if (i > 0) begin
        repeat (3) tick();
        check($sformatf("gap_busy_%0d", i), 32'(if_m.busy), 32'd1);
      end
    end
    check("gap_dout",  32'(if_m.dout),       32'hA5);
    check("gap_valid", 32'(if_m.dout_valid), 32'd1);
    consume();

    // Asynchronous reset mid-word
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    clrn = 1'b0;
    #1;
    check("arst_busy", 32'(if_m.busy), 32'd0);
    check("arst_dout", 32'(if_m.dout), 32'd0);
    tick();
    clrn = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("arst_valid_early", 32'(if_m.dout_valid), 32'd0);
    send_bit(1'b1);
    check("arst_dout_ff", 32'(if_m.dout),       32'hFF);
    check("arst_valid",   32'(if_m.dout_valid), 32'd1);
    consume();

    // Flush mid-word, with din_en asserted in the flush cycle
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    if_m.flush = 1'b1;
    send_bit(1'b1);
    if_m.flush = 1'b0;
    check("flush_busy", 32'(if_m.busy), 32'd0);
    w_seq = 8'h96;
    for (int i = 7; i >= 1; i--) send_bit(w_seq[i]);
    check("flush_valid_early", 32'(if_m.dout_valid), 32'd0);
    send_bit(w_seq[0]);
    check("flush_dout_96", 32'(if_m.dout), 32'h96);
    consume();

    // LSB-first instance
    send_bit_l(1'b1);
    for (int i = 0; i < 7; i++) send_bit_l(1'b0);
    check("lsb_dout_01",  32'(if_l.dout),       32'h01);
    check("lsb_valid_01", 32'(if_l.dout_valid), 32'd1);
    send_bit_l(1'b1);
    send_bit_l(1'b1);
    for (int i = 0; i < 6; i++) send_bit_l(1'b0);
    check("lsb_dout_03", 32'(if_l.dout), 32'h03);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
